// File: rtl/dpwm_duty_ctrl.sv
// Two-channel button-driven duty controller: sync, debounce and edge-detect four
// buttons, step two saturating duty registers, and drive period-aligned PWM outputs.
module dpwm_duty_ctrl #(
  parameter int W          = 8,
  parameter int STEP       = 16,
  parameter int INIT_DUTY  = 128,
  parameter int DEB_CYCLES = 500000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         PU1,
  input  logic         PD1,
  input  logic         PU2,
  input  logic         PD2,
  output logic [W-1:0] duty1,
  output logic [W-1:0] duty2,
  output logic         pwm1,
  output logic         pwm2
);

  localparam int            CW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [W:0]    STEP_X   = (W+1)'(STEP);
  localparam logic [W-1:0]  INIT_V   = W'(INIT_DUTY);
  localparam logic [W-1:0]  TOP      = '1;

  // Button index order: 0=PU1, 1=PD1, 2=PU2, 3=PD2.
  logic [3:0]    raw;
  logic [3:0]    s1;
  logic [3:0]    s2;
  logic [3:0]    stable;
  logic [3:0]    press;
  logic [CW-1:0] deb_cnt [4];

  logic [W-1:0]  cnt;
  logic [W-1:0]  shadow1;
  logic [W-1:0]  shadow2;

  assign raw = {PD2, PU2, PD1, PU1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // press is a one-cycle pulse on an accepted 0->1 change of the stable level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= '0;
      press  <= '0;
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        press[i] <= 1'b0;
        if (s2[i] == stable[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          stable[i]  <= s2[i];
          deb_cnt[i] <= '0;
          press[i]   <= s2[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  function automatic logic [W-1:0] next_duty(input logic [W-1:0] d,
                                             input logic up, input logic dn);
    logic [W:0] sum;
    logic [W:0] diff;
    sum       = {1'b0, d} + STEP_X;
    diff      = {1'b0, d} - STEP_X;
    next_duty = d;
    if (up && !dn)      next_duty = sum[W]  ? TOP : sum[W-1:0];
    else if (dn && !up) next_duty = diff[W] ? '0  : diff[W-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty1 <= INIT_V;
      duty2 <= INIT_V;
    end else begin
      duty1 <= next_duty(duty1, press[0], press[1]);
      duty2 <= next_duty(duty2, press[2], press[3]);
    end
  end

  // Shadows latch the pre-edge duty on the last count, so PWM never changes mid-period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      shadow1 <= INIT_V;
      shadow2 <= INIT_V;
      pwm1    <= 1'b0;
      pwm2    <= 1'b0;
    end else begin
      cnt  <= cnt + 1'b1;
      pwm1 <= (cnt < shadow1);
      pwm2 <= (cnt < shadow2);
      if (cnt == TOP) begin
        shadow1 <= duty1;
        shadow2 <= duty2;
      end
    end
  end

endmodule

// File: tb/tb_dpwm_duty_ctrl.sv
// Bench for dpwm_duty_ctrl: directed and random button activity against a
// press/saturation model, with per-cycle duty and per-period PWM high-count checks.
module tb_dpwm_duty_ctrl;
  localparam int W    = 8;
  localparam int STEP = 16;
  localparam int INIT = 128;
  localparam int DEB  = 4;
  localparam int LAT  = DEB + 3;
  localparam int PER  = 256;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         pu1 = 1'b0, pd1 = 1'b0, pu2 = 1'b0, pd2 = 1'b0;
  logic [W-1:0] duty1, duty2;
  logic         pwm1, pwm2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int m1    = INIT;
  int m2    = INIT;

  logic [W-1:0] exp1_q[$];
  logic [W-1:0] exp2_q[$];
  int           at1_q[$];
  int           at2_q[$];

  logic [W-1:0] cur1 = W'(INIT), cur2 = W'(INIT);
  logic [W-1:0] sh1 = W'(INIT), sh2 = W'(INIT), nx1 = W'(INIT), nx2 = W'(INIT);
  int           hi1 = 0, hi2 = 0;

  dpwm_duty_ctrl #(.W(W), .STEP(STEP), .INIT_DUTY(INIT), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst_n(rst_n),
    .PU1(pu1), .PD1(pd1), .PU2(pu2), .PD2(pd2),
    .duty1(duty1), .duty2(duty2), .pwm1(pwm1), .pwm2(pwm2)
  );

  // Clock / reset-relative edge counter: cyc == k after the k-th edge since release.
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic int step(input int d, input logic up, input logic dn);
    if (up && !dn) return (d + STEP > (1 << W) - 1) ? (1 << W) - 1 : d + STEP;
    if (dn && !up) return (d - STEP < 0) ? 0 : d - STEP;
    return d;
  endfunction

  // Scoreboard monitor: expected duty takes effect at its scheduled edge; each
  // finished period's PWM high count must equal the duty held just before it began.
  always @(negedge clk) begin
    if (!rst_n) begin
      cur1 = W'(INIT); cur2 = W'(INIT);
      sh1 = W'(INIT); sh2 = W'(INIT); nx1 = W'(INIT); nx2 = W'(INIT);
      hi1 = 0; hi2 = 0;
    end else begin
      if (at1_q.size() > 0 && at1_q[0] == cyc) begin
        void'(at1_q.pop_front());
        cur1 = exp1_q.pop_front();
      end
      if (at2_q.size() > 0 && at2_q[0] == cyc) begin
        void'(at2_q.pop_front());
        cur2 = exp2_q.pop_front();
      end
      check("duty1", duty1, cur1);
      check("duty2", duty2, cur2);
      hi1 += pwm1;
      hi2 += pwm2;
      if (cyc % PER == 0) begin
        check("pwm1_high", hi1, sh1);
        check("pwm2_high", hi2, sh2);
        hi1 = 0; hi2 = 0;
        sh1 = nx1; sh2 = nx2;
      end
      if (cyc % PER == PER - 1) begin
        nx1 = cur1;
        nx2 = cur2;
      end
    end
  end

  task automatic push1(input int at);
    at1_q.push_back(at);
    exp1_q.push_back(W'(m1));
  endtask

  task automatic push2(input int at);
    at2_q.push_back(at);
    exp2_q.push_back(W'(m2));
  endtask

  // Raise the given buttons together, hold for 'hold' clocks, release, idle 'gap'.
  task automatic drive(input logic u1, input logic d1, input logic u2, input logic d2,
                       input int hold, input int gap);
    int c0;
    @(negedge clk);
    c0 = cyc;
    pu1 = u1; pd1 = d1; pu2 = u2; pd2 = d2;
    if (hold >= DEB) begin
      if (u1 || d1) begin m1 = step(m1, u1, d1); push1(c0 + LAT); end
      if (u2 || d2) begin m2 = step(m2, u2, d2); push2(c0 + LAT); end
    end
    repeat (hold) @(negedge clk);
    pu1 = 1'b0; pd1 = 1'b0; pu2 = 1'b0; pd2 = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Asynchronous reset between edges; outputs must clear before any clock edge.
  task automatic apply_reset(input logic keep_pu1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_duty1", duty1, INIT);
    check("rst_duty2", duty2, INIT);
    check("rst_pwm1", pwm1, 0);
    check("rst_pwm2", pwm2, 0);
    at1_q.delete(); exp1_q.delete(); at2_q.delete(); exp2_q.delete();
    m1 = INIT; m2 = INIT;
    if (!keep_pu1) pu1 = 1'b0;
    pd1 = 1'b0; pu2 = 1'b0; pd2 = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    apply_reset(1'b0);
    repeat (1024) @(negedge clk);

    drive(1'b1, 1'b0, 1'b0, 1'b0, 20, 10);

    drive(1'b1, 1'b0, 1'b0, 1'b0, 3, 10);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      pu1 = (i % 2 == 0);
      @(negedge clk);
    end
    pu1 = 1'b0;
    repeat (10) @(negedge clk);

    for (int i = 0; i < 9; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, 6, 9);
    repeat (600) @(negedge clk);

    apply_reset(1'b0);
    for (int i = 0; i < 9; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 5, 8);
    repeat (600) @(negedge clk);

    apply_reset(1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 10, 10);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 10, 10);

    for (int i = 0; i < 40; i++)
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(1, 12), $urandom_range(8, 14));
    repeat (520) @(negedge clk);

    apply_reset(1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5, 8);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5, 8);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5, 8);
    @(negedge clk);
    pu1 = 1'b1;
    repeat (3) @(negedge clk);
    apply_reset(1'b1);
    m1 = step(m1, 1'b1, 1'b0);
    push1(LAT);
    repeat (12) @(negedge clk);
    pu1 = 1'b0;
    repeat (300) @(negedge clk);

    check("pending1", at1_q.size(), 0);
    check("pending2", at2_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dpwm_duty_ctrl.md
Name: dpwm_duty_ctrl

Overview:
- Consumer end of the push-button routing path. Takes the two routed up/down button pairs (PU1/PD1 for channel 1, PU2/PD2 for channel 2), which are raw mechanical levels.
- Per channel, it synchronizes, debounces and edge-detects each button, then steps a saturating duty-cycle register.
- Drives two glitch-free PWM outputs from a shared free-running period counter.
- Duty changes take effect only at period boundaries.

Parameters:
- W, 8: duty and period-counter width; PWM period = 2^W clocks.
- STEP, 16: duty increment/decrement per accepted press.
- INIT_DUTY, 128: duty value after reset, for both channels.
- DEB_CYCLES, 500000: consecutive clocks a synchronized input must differ from its stable level before the change is accepted. Must be >= 1; benches override it to 4.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- PU1, input, 1: channel 1 up button, raw and asynchronous.
- PD1, input, 1: channel 1 down button, raw and asynchronous.
- PU2, input, 1: channel 2 up button, raw and asynchronous.
- PD2, input, 1: channel 2 down button, raw and asynchronous.
- duty1, output, W: channel 1 target duty register.
- duty2, output, W: channel 2 target duty register.
- pwm1, output, 1: channel 1 PWM, registered.
- pwm2, output, 1: channel 2 PWM, registered.

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n), and it clears state immediately without waiting for clk.
- Reset values:
  - all synchronizer FFs, debounce counters, stable levels and press pulses = 0
  - duty1 = duty2 = INIT_DUTY; shadow1 = shadow2 = INIT_DUTY
  - period counter cnt = 0
  - pwm1 = pwm2 = 0
- Reset asserted mid-press or mid-period aborts everything. After release, a button already held high counts as a fresh press once fully debounced, because the stable level restarts at 0.
- Synchronizer: two FFs per button (4 chains). s2 is the synchronized level.
- Debounce, per button, independent:
  - s2 == stable: counter <= 0.
  - s2 != stable and counter < DEB_CYCLES-1: counter increments.
  - s2 != stable and counter == DEB_CYCLES-1: stable <= s2, counter <= 0, press <= s2 (the 0->1 transition only).
  - press is a registered one-cycle pulse. A glitch shorter than DEB_CYCLES clocks is ignored.
  - A held button produces exactly one press. Release produces none.
- Latency: raw input first sampled high at edge E1 and held gives press high after edge E(2+DEB_CYCLES). The duty register changes at edge E(3+DEB_CYCLES).
- Duty update, per channel, at each edge:
  - up press only: duty <= min(duty+STEP, 2^W-1), computed in W+1 bits.
  - down press only: duty <= max(duty-STEP, 0), computed signed / with borrow check.
  - both presses in the same cycle: duty holds.
  - neither: duty holds.
  - Channels are fully independent; simultaneous presses on both channels each apply.
- Period counter: cnt increments every clock and wraps from 2^W-1 to 0.
- Shadow load: on the edge where cnt == 2^W-1, shadowN <= dutyN, using the duty value present before that edge. A duty update on that same edge is taken in the following period.
- PWM: pwmN <= (cnt < shadowN), registered.
  - pwmN is high for exactly shadowN clocks of every 2^W-clock period, lagging cnt by one clock.
  - shadow = 0: constant low.
  - shadow = 2^W-1: low for 1 clock per period.
- No output changes except on a clk edge or on rst_n assertion.

Test Plan:
All scenarios use W=8, STEP=16, INIT_DUTY=128, DEB_CYCLES=4.

1. Reset then idle 1024 clocks -> duty1 = duty2 = 128; pwm1 and pwm2 each high exactly 128 of every 256 clocks, all periods identical.
2. PU1 raised and held 20 clocks -> duty1 becomes 144 exactly 7 edges after first sampling, one step only; duty2 stays 128. pwm1 high count becomes 144 starting the period after the next cnt wrap, never mid-period.
3. PU1 pulsed high for 3 clocks (shorter than the debounce window), and separately bounced 1-0-1-0 every clock for 10 clocks -> no press, duty1 = 128.
4. Seven clean PD2 presses from 128 -> duty2 sequence 112, 96, 80, 64, 48, 32, 16. Two more presses -> 0 and 0; pwm2 then constant low. From 240, an up press -> 255 and a further up press -> 255; pwm high 255 of 256 clocks.
5. PU1 and PD1 rising on the same clock and held -> both presses in the same cycle, duty1 unchanged at 128. PU1 and PU2 together -> duty1 = duty2 = 144.
6. rst_n low asynchronously mid-period, with duty1 = 176 and a debounce half complete -> outputs reset immediately with no clk edge needed. After release with PU1 still held high, one press is accepted: duty1 = 144 after 7 edges.
